// File: rtl/alu_pkg.sv
// Shared ALU definitions: op and condition encodings, default width,
// and the condition evaluation helper used by the arbiter.
package alu_pkg;

    localparam int W_DEFAULT = 16;

    // sel: 00 add, 01 nand, 1x add
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_NAND = 2'b01;

    typedef enum logic [1:0] {
        COND_ALWAYS  = 2'b00,
        COND_ZERO    = 2'b01,
        COND_CARRY   = 2'b10,
        COND_ALWAYS2 = 2'b11
    } alu_cond_e;

    // True when an execute op with this condition may run.
    function automatic logic cond_ok(input logic [1:0] cond,
                                     input logic       carry,
                                     input logic       zero);
        case (cond)
            COND_CARRY: cond_ok = carry;
            COND_ZERO:  cond_ok = zero;
            default:    cond_ok = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Team ALU: combinational add / bitwise NAND on W-bit operands.
// is_add tells the caller whether carry is meaningful for this op.
module alu
    import alu_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         is_add
);

    logic [W:0] sum;

    // Select between the W+1-bit sum and the bitwise NAND.
    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[W-1:0];
        carry  = sum[W];
        is_add = 1'b1;
        if (sel == OP_NAND) begin
            result = ~(a & b);
            carry  = 1'b0;
            is_add = 1'b0;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared ALU. Requester 0 is the fetch/PC
// path, requester 1 the execute path, which owns the carry/zero flags and
// may be conditionally suppressed.
// Build option: define ALU_ARB_RR_EN for round-robin conflict resolution;
// otherwise requester 1 always wins conflicts.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_sel,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_sel,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [1:0]   req1_cond,
    input  logic         req1_flag_we,
    output logic         rsp0_valid,
    output logic [W-1:0] rsp0_data,
    output logic         rsp1_valid,
    output logic [W-1:0] rsp1_data,
    output logic         rsp1_skipped,
    output logic         carry_flag,
    output logic         zero_flag
);

    // 1 = requester 1 won the most recent transfer
    logic         last_grant;
    logic         pick0;
    logic         xfer0, xfer1;
    logic         pass;
    logic [1:0]   op_sel;
    logic [W-1:0] op_a, op_b;
    logic [W-1:0] alu_res;
    logic         alu_carry, alu_is_add;

`ifdef ALU_ARB_RR_EN
    // Conflict goes to whoever did not win last time.
    assign pick0 = last_grant;
`else
    // Execute path always wins conflicts.
    assign pick0 = 1'b0;
`endif

    // Grants depend only on valids, reset and arbitration state.
    assign req0_ready = rst_n & req0_valid & ~(req1_valid & ~pick0);
    assign req1_ready = rst_n & req1_valid & ~(req0_valid &  pick0);

    assign xfer0 = req0_valid & req0_ready;
    assign xfer1 = req1_valid & req1_ready;

    // Flags as registered now, so a back-to-back op sees the previous write.
    assign pass = cond_ok(req1_cond, carry_flag, zero_flag);

    assign op_sel = req1_ready ? req1_sel : req0_sel;
    assign op_a   = req1_ready ? req1_a   : req0_a;
    assign op_b   = req1_ready ? req1_b   : req0_b;

    alu #(.W(W)) u_alu (
        .sel    (op_sel),
        .a      (op_a),
        .b      (op_b),
        .result (alu_res),
        .carry  (alu_carry),
        .is_add (alu_is_add)
    );

    // Arbitration history; reset to 1 so requester 0 wins the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant <= 1'b1;
        else        last_grant <= (xfer0 | xfer1) ? xfer1 : last_grant;
    end

    // Fetch-path response: one-cycle pulse, data held until the next transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
        end else begin
            rsp0_valid <= xfer0;
            if (xfer0) rsp0_data <= alu_res;
        end
    end

    // Execute-path response and flag update; suppressed ops return zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp1_valid   <= 1'b0;
            rsp1_skipped <= 1'b0;
            rsp1_data    <= '0;
            carry_flag   <= 1'b0;
            zero_flag    <= 1'b0;
        end else begin
            rsp1_valid   <= xfer1;
            rsp1_skipped <= xfer1 & ~pass;
            if (xfer1) begin
                rsp1_data <= pass ? alu_res : '0;
                if (pass && req1_flag_we) begin
                    zero_flag <= (alu_res == '0);
                    if (alu_is_add) carry_flag <= alu_carry;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with hand-computed expectations.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [1:0]  req0_sel;
    logic [15:0] req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [1:0]  req1_sel;
    logic [15:0] req1_a, req1_b;
    logic [1:0]  req1_cond;
    logic        req1_flag_we;
    logic        rsp0_valid, rsp1_valid, rsp1_skipped;
    logic [15:0] rsp0_data, rsp1_data;
    logic        carry_flag, zero_flag;

    int n_chk = 0;
    int n_err = 0;

    alu_arbiter #(.W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
        .req1_a(req1_a), .req1_b(req1_b), .req1_cond(req1_cond),
        .req1_flag_we(req1_flag_we),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_skipped(rsp1_skipped),
        .carry_flag(carry_flag), .zero_flag(zero_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Present one request on a single port, check its grant, cross one edge.
    task automatic send(input bit port, input logic [1:0] sel, input logic [15:0] a,
                        input logic [15:0] b, input logic [1:0] cond, input logic we);
        req0_valid = !port; req1_valid = port;
        if (port) begin
            req1_sel = sel; req1_a = a; req1_b = b; req1_cond = cond; req1_flag_we = we;
        end else begin
            req0_sel = sel; req0_a = a; req0_b = b;
        end
        #1;
        chk("rdy0", req0_ready, !port);
        chk("rdy1", req1_ready, port);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        req0_valid = 0; req1_valid = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 0;
        req0_valid = 1; req1_valid = 1;
        req0_sel = 0; req0_a = 0; req0_b = 0;
        req1_sel = 0; req1_a = 0; req1_b = 0; req1_cond = 0; req1_flag_we = 0;
        #12;
        chk("rst_rdy0", req0_ready, 0);
        chk("rst_rdy1", req1_ready, 0);
        chk("rst_outs", {rsp0_valid, rsp1_valid, rsp1_skipped, carry_flag, zero_flag}, 0);
        chk("rst_data", {rsp0_data, rsp1_data}, 0);
        req0_valid = 0; req1_valid = 0;
        @(negedge clk) rst_n = 1;

        // FFFF + 1 on execute path: wraps to 0, carry and zero set
        send(1, 2'b00, 16'hFFFF, 16'h0001, 2'b00, 1);
        chk("add_v",    rsp1_valid, 1);
        chk("add_d",    rsp1_data, 16'h0000);
        chk("add_c",    carry_flag, 1);
        chk("add_z",    zero_flag, 1);
        chk("add_skip", rsp1_skipped, 0);
        idle();
        chk("pulse1", rsp1_valid, 0);

        // NAND FFFF,FFFF = 0: zero set, carry kept at 1
        send(1, 2'b01, 16'hFFFF, 16'hFFFF, 2'b00, 1);
        chk("nand_d", rsp1_data, 16'h0000);
        chk("nand_z", zero_flag, 1);
        chk("nand_c", carry_flag, 1);

        // 1+1 clears both flags; then carry-conditional op is suppressed
        send(1, 2'b10, 16'h0001, 16'h0001, 2'b00, 1);
        chk("add2_d", rsp1_data, 16'h0002);
        chk("add2_cz", {carry_flag, zero_flag}, 2'b00);
        send(1, 2'b00, 16'h0001, 16'h0001, 2'b10, 1);
        chk("skip_v",  rsp1_valid, 1);
        chk("skip_s",  rsp1_skipped, 1);
        chk("skip_d",  rsp1_data, 16'h0000);
        chk("skip_cz", {carry_flag, zero_flag}, 2'b00);
        idle();
        chk("skip_clr", {rsp1_valid, rsp1_skipped}, 2'b00);

        // Fetch-path add 8000+8000 -> 0, flags untouched
        send(0, 2'b00, 16'h8000, 16'h8000, 2'b00, 0);
        chk("r0_v",  rsp0_valid, 1);
        chk("r0_d",  rsp0_data, 16'h0000);
        chk("r0_cz", {carry_flag, zero_flag}, 2'b00);

        // Back-to-back: carry written by first op enables the second
        send(1, 2'b00, 16'hFFFF, 16'h0001, 2'b00, 1);
        chk("dep1_c", carry_flag, 1);
        send(1, 2'b00, 16'h0002, 16'h0003, 2'b10, 0);
        chk("dep2_d", rsp1_data, 16'h0005);
        chk("dep2_s", rsp1_skipped, 0);
        idle();

        // Conflict for four cycles; last winner was requester 1
        req0_sel = 0; req0_a = 16'h0001; req0_b = 16'h0001;
        req1_sel = 0; req1_a = 16'h0010; req1_b = 16'h0010; req1_cond = 0; req1_flag_we = 0;
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 4; i++) begin
            bit g1;
`ifdef ALU_ARB_RR_EN
            g1 = (i % 2) == 1;
`else
            g1 = 1'b1;
`endif
            #1;
            chk("arb_rdy0", req0_ready, !g1);
            chk("arb_rdy1", req1_ready, g1);
            @(posedge clk); #1;
            chk("arb_rsp", {rsp0_valid, rsp1_valid}, {!g1, g1});
        end
        idle();

        // Reset right after a transfer: response and flags dropped
        send(1, 2'b00, 16'hFFFF, 16'h0001, 2'b00, 1);
        rst_n = 0;
        #1;
        chk("mrst_outs", {rsp0_valid, rsp1_valid, rsp1_skipped, carry_flag, zero_flag}, 0);
        chk("mrst_data", {rsp0_data, rsp1_data}, 0);
        chk("mrst_rdy", {req0_ready, req1_ready}, 0);
        @(posedge clk); #1;
        chk("mrst_rdy2", {req0_ready, req1_ready}, 0);
        req1_valid = 0;
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        chk("mrst_nopulse", {rsp0_valid, rsp1_valid}, 0);
        send(0, 2'b00, 16'h0003, 16'h0004, 2'b00, 0);
        chk("resume_d", rsp0_data, 16'h0007);
        chk("resume_v", rsp0_valid, 1);
        idle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter W, default 16, meaning operand/result width.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  request present (0 = fetch/PC path, 1 = execute path).
REQ-005 SHALL have ports req0_ready/req1_ready  output  1  grant this cycle; transfer when valid&ready at clock edge.
REQ-006 SHALL have ports reqN_sel  input  2  op: 00 add, 01 bitwise NAND, 1x add.
REQ-007 SHALL have ports reqN_a, reqN_b  input  W  operands.
REQ-008 SHALL have port req1_cond  input  2  execute condition: 00 always, 10 only if carry_flag, 01 only if zero_flag, 11 always.
REQ-009 SHALL have port req1_flag_we  input  1  granted execute op may update flags.
REQ-010 SHALL have ports rsp0_valid/rsp1_valid  output  1  one-cycle result pulse per granted request.
REQ-011 SHALL have ports rsp0_data/rsp1_data  output  W  registered result.
REQ-012 SHALL have port rsp1_skipped  output  1  execute op suppressed by condition.
REQ-013 SHALL have ports carry_flag, zero_flag  output  1  architectural flag registers.

Function
REQ-014 SHALL grant at most one requester per cycle; reqN_ready combinational from valids and arbitration state only, never from ready.
REQ-015 SHALL, with one valid requester, grant it that cycle.
REQ-016 SHALL, on conflict, arbitrate per REQ-030/031; state bit last_grant records winner at each transfer edge.
REQ-017 SHALL compute add as W+1-bit sum; result = low W bits, carry = bit W.
REQ-018 SHALL compute NAND bitwise (~(a&b)); NAND leaves carry_flag unchanged.
REQ-019 SHALL register result: transfer at edge N -> rspN_valid=1 and rspN_data valid during cycle N+1, pulse exactly one cycle; no back-pressure on responses.
REQ-020 SHALL evaluate req1_cond against flag register values present in the grant cycle.
REQ-021 SHALL, for suppressed execute op, still assert rsp1_valid, with rsp1_skipped=1, rsp1_data=0, flags unchanged.
REQ-022 SHALL update flags at the transfer edge only for req1 transfers not suppressed with req1_flag_we=1: zero_flag = (result==0); carry_flag per REQ-017/018.
REQ-023 SHALL never modify flags on req0 transfers.
REQ-024 SHALL make back-to-back dependent execute ops see flags written by the previous transfer (no bubble).
REQ-025 SHALL keep rsp1_skipped=0 whenever rsp1_valid=0.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear rsp0_valid, rsp1_valid, rsp1_skipped, rsp0_data, rsp1_data, carry_flag, zero_flag, last_grant (=1, so req0 wins first conflict).
REQ-027 SHALL, while rst_n low, hold req0_ready=req1_ready=0.
REQ-028 SHALL drop any in-flight response when reset asserts mid-operation; no pulse after release.
REQ-029 SHALL resume arbitration on the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL, with ALU_ARB_RR_EN defined, use round-robin: conflict winner = requester not in last_grant.
REQ-031 SHALL, without ALU_ARB_RR_EN, use fixed priority: req1 always wins conflicts; last_grant still maintained but unused.

Structure
REQ-032 SHALL take op encodings (OP_ADD, OP_NAND), condition encodings and W default from shared package alu_pkg.
REQ-033 SHALL instantiate the team ALU as sole sub-module alu, fed by the granted requester's sel/operands via a mux.

Verification
REQ-034 SHALL cover: reset release, req1 add 16'hFFFF+16'h0001 -> next cycle rsp1_data=0, carry_flag=1, zero_flag=1.
REQ-035 SHALL cover: both valid 4 cycles with ALU_ARB_RR_EN -> grants 0,1,0,1; without -> 1,1,1,1, req0 starved.
REQ-036 SHALL cover: carry_flag=0, req1 cond=10 -> rsp1_valid=1, rsp1_skipped=1, rsp1_data=0, flags unchanged.
REQ-037 SHALL cover: req0 add 16'h8000+16'h8000 -> rsp0_data=0, flags unchanged.
REQ-038 SHALL cover: req1 NAND 16'hFFFF,16'hFFFF with carry_flag=1 -> rsp1_data=0, zero_flag=1, carry_flag=1.
REQ-039 SHALL cover: rst_n low the cycle after a transfer -> no response pulse, all outputs zero, ready low until release.
